// File: rtl/vid_pkg.sv
// Shared definitions for the pixel-stream checker: error flag bit positions
// and the checker FSM state encoding.
package vid_pkg;

   localparam int unsigned ERR_WIDTH  = 0;
   localparam int unsigned ERR_HEIGHT = 1;
   localparam int unsigned ERR_DATA   = 2;
   localparam int unsigned ERR_PROTO  = 3;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      WAIT  = 2'd1,
      FRAME = 2'd2
   } chk_state_t;

endpackage

// File: rtl/edge_det.sv
// Registered edge detector: keeps the previous sample of din and flags
// rising and falling transitions against it.
module edge_det (
   input  logic pixclk,
   input  logic rst,
   input  logic din,
   output logic din_d,
   output logic rise,
   output logic fall
);

   always_ff @(posedge pixclk or posedge rst) begin
      if (rst) din_d <= 1'b0;
      else     din_d <= din;
   end

   always_comb begin
      rise = din & ~din_d;
      fall = ~din & din_d;
   end

endmodule

// File: rtl/frm_chk.sv
// Pixel-stream receiver: measures line width / frame height, checks the
// per-line ramp pattern and publishes per-frame results on vs fall.
module frm_chk
   import vid_pkg::*;
#(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int DWIDTH  = 8,
   parameter int CWIDTH  = 12,
   parameter int ECWIDTH = 16
) (
   input  logic               pixclk,
   input  logic               rst,
   input  logic               image_vs,
   input  logic               image_valid,
   input  logic [DWIDTH-1:0]  image_data,
   output logic               frame_done,
   output logic [CWIDTH-1:0]  meas_width,
   output logic [CWIDTH-1:0]  meas_height,
   output logic [ECWIDTH-1:0] err_data_cnt,
   output logic [3:0]         err_flags,
   output logic [ECWIDTH-1:0] frame_cnt
);

   localparam logic [CWIDTH-1:0] W_EXP = CWIDTH'(FRAME_W);
   localparam logic [CWIDTH-1:0] H_EXP = CWIDTH'(FRAME_H);

   function automatic logic [CWIDTH-1:0] inc_c(input logic [CWIDTH-1:0] v);
      return (v == '1) ? v : v + CWIDTH'(1);
   endfunction

   function automatic logic [ECWIDTH-1:0] inc_e(input logic [ECWIDTH-1:0] v);
      return (v == '1) ? v : v + ECWIDTH'(1);
   endfunction

   chk_state_t         state;
   logic [CWIDTH-1:0]  pix_idx;
   logic [CWIDTH-1:0]  line_cnt;
   logic [CWIDTH-1:0]  last_width;
   logic [ECWIDTH-1:0] data_err_cnt;
   logic               width_err;
   logic               data_err;
   logic               proto_err;
   logic               proto_pend;

   logic vs_d, vs_rise, vs_fall;
   logic valid_d, valid_rise, valid_fall;
   logic unused_edges;

   edge_det u_vs_edge (
      .pixclk (pixclk),
      .rst    (rst),
      .din    (image_vs),
      .din_d  (vs_d),
      .rise   (vs_rise),
      .fall   (vs_fall)
   );

   edge_det u_valid_edge (
      .pixclk (pixclk),
      .rst    (rst),
      .din    (image_valid),
      .din_d  (valid_d),
      .rise   (valid_rise),
      .fall   (valid_fall)
   );

   assign unused_edges = ^{vs_d, vs_rise, valid_rise};

   logic               pix_hit;
   logic [CWIDTH-1:0]  cmp_idx;
   logic               pix_bad;
   logic               line_close;
   logic               frame_close;
   logic [CWIDTH-1:0]  close_width;
   logic [CWIDTH-1:0]  close_height;
   logic [3:0]         close_flags;

   always_comb begin
      pix_hit      = image_valid & image_vs;
      // The frame-entry cycle (still WAIT) checks its pixel as index 0.
      cmp_idx      = (state == WAIT) ? '0 : pix_idx;
      pix_bad      = pix_hit & (image_data != cmp_idx[DWIDTH-1:0]);
      line_close   = (state == FRAME) & (valid_fall | (vs_fall & valid_d));
      frame_close  = (state == FRAME) & vs_fall;
      // A line closing on the vs-fall edge is folded into the frame results.
      close_width  = line_close ? pix_idx : last_width;
      close_height = line_close ? inc_c(line_cnt) : line_cnt;
      close_flags  = '0;
      close_flags[ERR_WIDTH]  = width_err | (line_close & (pix_idx != W_EXP));
      close_flags[ERR_HEIGHT] = (close_height != H_EXP);
      close_flags[ERR_DATA]   = data_err;
      close_flags[ERR_PROTO]  = proto_err;
   end

   always_ff @(posedge pixclk or posedge rst) begin
      if (rst) begin
         state        <= SYNC;
         pix_idx      <= '0;
         line_cnt     <= '0;
         last_width   <= '0;
         data_err_cnt <= '0;
         width_err    <= 1'b0;
         data_err     <= 1'b0;
         proto_err    <= 1'b0;
         proto_pend   <= 1'b0;
         frame_done   <= 1'b0;
         meas_width   <= '0;
         meas_height  <= '0;
         err_data_cnt <= '0;
         err_flags    <= '0;
         frame_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            SYNC: begin
               if (!image_vs) state <= WAIT;
            end

            WAIT: begin
               if (image_vs) begin
                  state        <= FRAME;
                  pix_idx      <= CWIDTH'(pix_hit);
                  line_cnt     <= '0;
                  last_width   <= '0;
                  data_err_cnt <= ECWIDTH'(pix_bad);
                  width_err    <= 1'b0;
                  data_err     <= pix_bad;
                  proto_err    <= proto_pend;
                  proto_pend   <= 1'b0;
               end else if (image_valid) begin
                  proto_pend <= 1'b1;
               end
            end

            FRAME: begin
               if (pix_hit) begin
                  if (pix_bad) begin
                     data_err_cnt <= inc_e(data_err_cnt);
                     data_err     <= 1'b1;
                  end
                  pix_idx <= inc_c(pix_idx);
               end
               if (line_close) begin
                  line_cnt   <= inc_c(line_cnt);
                  last_width <= pix_idx;
                  if (pix_idx != W_EXP) width_err <= 1'b1;
                  pix_idx    <= '0;
               end
               if (image_valid && !image_vs) proto_pend <= 1'b1;
               if (frame_close) begin
                  state        <= WAIT;
                  frame_done   <= 1'b1;
                  meas_width   <= close_width;
                  meas_height  <= close_height;
                  err_data_cnt <= data_err_cnt;
                  err_flags    <= close_flags;
                  frame_cnt    <= inc_e(frame_cnt);
               end
            end

            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_frm_chk.sv
// Self-checking bench for frm_chk (FRAME_W=16, FRAME_H=4): table-driven frames,
// randomized frames against a frame-level reference model, and reset corners.
module tb_frm_chk;

   localparam int W    = 16;
   localparam int H    = 4;
   localparam int CMAX = (1 << 12) - 1;

   logic        pixclk = 1'b0;
   logic        rst;
   logic        image_vs;
   logic        image_valid;
   logic [7:0]  image_data;
   logic        frame_done;
   logic [11:0] meas_width;
   logic [11:0] meas_height;
   logic [15:0] err_data_cnt;
   logic [3:0]  err_flags;
   logic [15:0] frame_cnt;

   frm_chk #(
      .FRAME_W (W),
      .FRAME_H (H),
      .DWIDTH  (8),
      .CWIDTH  (12),
      .ECWIDTH (16)
   ) dut (
      .pixclk       (pixclk),
      .rst          (rst),
      .image_vs     (image_vs),
      .image_valid  (image_valid),
      .image_data   (image_data),
      .frame_done   (frame_done),
      .meas_width   (meas_width),
      .meas_height  (meas_height),
      .err_data_cnt (err_data_cnt),
      .err_flags    (err_flags),
      .frame_cnt    (frame_cnt)
   );

   always #5 pixclk = ~pixclk;

   int n_checks = 0;
   int n_err    = 0;
   int done_seen = 0;
   int exp_done  = 0;
   int exp_fc    = 0;

   always @(negedge pixclk) if (frame_done === 1'b1) done_seen++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Current frame description shared by the driver and the reference model.
   int fr_n;
   int fr_len  [8];
   int fr_cpix [8];
   int fr_cval [8];
   int fr_tail, fr_pre, fr_hb, fr_proto;

   typedef struct {
      int nl; int sidx; int slen; int cl; int cp; int cval;
      int tail; int pre; int proto;
      int ew; int eh; int ee; logic [3:0] ef;
   } vec_t;

   task automatic tick();
      @(posedge pixclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] data_of(input int l, input int k);
      if (k == fr_cpix[l]) return 8'(fr_cval[l]);
      return 8'(k);
   endfunction

   // Frame-level reference: results follow directly from the line lengths
   // and the pixel values actually sent.
   task automatic model(output int w, output int h, output int e, output logic [3:0] f);
      int wbad, m, ei;
      w = 0; e = 0; wbad = 0;
      for (int l = 0; l < fr_n; l++) begin
         m = (fr_len[l] > CMAX) ? CMAX : fr_len[l];
         w = m;
         if (m != W) wbad = 1;
         for (int k = 0; k < fr_len[l]; k++) begin
            ei = ((k > CMAX) ? CMAX : k) % 256;
            if (int'(data_of(l, k)) != ei && e < 65535) e++;
         end
      end
      h = fr_n;
      f = {fr_proto != 0, e > 0, h != H, wbad != 0};
   endtask

   task automatic run_frame(input string tag, input int ew, input int eh,
                            input int ee, input logic [3:0] ef);
      int tl;
      image_vs = 1'b0; image_valid = 1'b0;
      tick(); tick();
      if (fr_proto != 0) begin
         image_valid = 1'b1; image_data = 8'hA5;
         tick(); tick();
         image_valid = 1'b0;
         tick();
      end
      tick(); tick();
      image_vs = 1'b1;
      for (int i = 0; i < fr_pre; i++) tick();
      for (int l = 0; l < fr_n; l++) begin
         for (int k = 0; k < fr_len[l]; k++) begin
            image_valid = 1'b1;
            image_data  = data_of(l, k);
            tick();
         end
         image_valid = 1'b0;
         if (l < fr_n - 1) for (int i = 0; i < fr_hb; i++) tick();
      end
      tl = fr_tail;
      if (fr_n == 0 && fr_pre + tl == 0) tl = 1;
      for (int i = 0; i < tl; i++) tick();
      image_vs = 1'b0;
      tick();
      exp_done++;
      if (exp_fc < 65535) exp_fc++;
      chk({tag, " frame_done"}, frame_done, 1);
      chk({tag, " meas_width"}, meas_width, ew);
      chk({tag, " meas_height"}, meas_height, eh);
      chk({tag, " err_data_cnt"}, err_data_cnt, ee);
      chk({tag, " err_flags"}, err_flags, ef);
      chk({tag, " frame_cnt"}, frame_cnt, exp_fc);
      tick();
      chk({tag, " frame_done_pulse"}, frame_done, 0);
      chk({tag, " meas_height_hold"}, meas_height, eh);
   endtask

   task automatic set_nominal(input int n);
      fr_n = n; fr_tail = 2; fr_pre = 1; fr_hb = 2; fr_proto = 0;
      for (int l = 0; l < 8; l++) begin
         fr_len[l] = W; fr_cpix[l] = -1; fr_cval[l] = 0;
      end
   endtask

   vec_t tbl [11];
   int   mw, mh, me, done_before;
   logic [3:0] mf;

   initial begin
      tbl[0]  = '{4, -1,  0, -1,  0, 0, 2, 1, 0, 16, 4, 0, 4'b0000};
      tbl[1]  = '{4, -1,  0, -1,  0, 0, 2, 1, 0, 16, 4, 0, 4'b0000};
      tbl[2]  = '{4, -1,  0, -1,  0, 0, 4, 1, 0, 16, 4, 0, 4'b0000};
      tbl[3]  = '{4, -1,  0,  2,  5, 8'hFF, 2, 1, 0, 16, 4, 1, 4'b0100};
      tbl[4]  = '{5,  1, 15, -1,  0, 0, 2, 1, 0, 16, 5, 0, 4'b0011};
      tbl[5]  = '{4, -1,  0, -1,  0, 0, 2, 1, 1, 16, 4, 0, 4'b1000};
      tbl[6]  = '{4, -1,  0, -1,  0, 0, 0, 1, 0, 16, 4, 0, 4'b0000};
      tbl[7]  = '{0, -1,  0, -1,  0, 0, 3, 1, 0,  0, 0, 0, 4'b0010};
      tbl[8]  = '{4, -1,  0, -1,  0, 0, 1, 0, 0, 16, 4, 0, 4'b0000};
      tbl[9]  = '{4,  3, 15, -1,  0, 0, 0, 0, 0, 15, 4, 0, 4'b0001};
      tbl[10] = '{4,  0, 17,  0, 16, 0, 2, 1, 0, 16, 4, 1, 4'b0101};

      rst = 1'b1; image_vs = 1'b0; image_valid = 1'b0; image_data = '0;
      tick(); tick(); tick();
      chk("rst frame_done", frame_done, 0);
      chk("rst meas_width", meas_width, 0);
      chk("rst meas_height", meas_height, 0);
      chk("rst err_data_cnt", err_data_cnt, 0);
      chk("rst err_flags", err_flags, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         set_nominal(tbl[i].nl);
         if (tbl[i].sidx >= 0) fr_len[tbl[i].sidx] = tbl[i].slen;
         if (tbl[i].cl >= 0) begin
            fr_cpix[tbl[i].cl] = tbl[i].cp;
            fr_cval[tbl[i].cl] = tbl[i].cval;
         end
         fr_tail = tbl[i].tail; fr_pre = tbl[i].pre; fr_proto = tbl[i].proto;
         run_frame($sformatf("tbl%0d", i), tbl[i].ew, tbl[i].eh, tbl[i].ee, tbl[i].ef);
      end

      // Line longer than the counter range: width saturates, pixels past
      // the saturation point are compared against the frozen index.
      set_nominal(1);
      fr_len[0] = CMAX + 5;
      run_frame("ovf", CMAX, 1, 4, 4'b0111);

      for (int r = 0; r < 25; r++) begin
         set_nominal($urandom_range(0, 6));
         for (int l = 0; l < fr_n; l++) begin
            if ($urandom_range(0, 1) == 0) fr_len[l] = $urandom_range(1, 20);
            if ($urandom_range(0, 9) < 3) begin
               fr_cpix[l] = $urandom_range(0, fr_len[l] - 1);
               fr_cval[l] = (fr_cpix[l] % 256) ^ int'($urandom_range(1, 255));
            end
         end
         fr_tail  = $urandom_range(0, 3);
         fr_pre   = $urandom_range(0, 2);
         fr_hb    = $urandom_range(1, 3);
         fr_proto = ($urandom_range(0, 4) == 0) ? 1 : 0;
         model(mw, mh, me, mf);
         run_frame($sformatf("rnd%0d", r), mw, mh, me, mf);
      end

      // Asynchronous reset, then release in the middle of a frame.
      rst = 1'b1;
      #2;
      chk("async_rst frame_cnt", frame_cnt, 0);
      chk("async_rst meas_width", meas_width, 0);
      chk("async_rst err_flags", err_flags, 0);
      tick(); tick();
      exp_fc = 0;
      done_before = done_seen;
      image_vs = 1'b1;
      for (int k = 0; k < 8; k++) begin
         image_valid = 1'b1; image_data = 8'(k);
         if (k == 3) rst = 1'b0;
         tick();
      end
      image_valid = 1'b0;
      tick(); tick();
      for (int k = 0; k < W; k++) begin
         image_valid = 1'b1; image_data = 8'(k);
         tick();
      end
      image_valid = 1'b0;
      tick();
      image_vs = 1'b0;
      tick(); tick(); tick();
      chk("partial no frame_done", done_seen, done_before);
      chk("partial meas_height", meas_height, 0);
      chk("partial frame_cnt", frame_cnt, 0);
      set_nominal(4);
      run_frame("post_rst", W, H, 0, 4'b0000);

      tick(); tick();
      chk("frame_done total", done_seen, exp_done);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
